seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
- Parametrised, time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits.
- Holds a display value, decodes one nibble per scan slot into active-low segments, and drives one active-low anode per slot.
- Value updates are double-buffered so they take effect only on frame boundaries, which prevents tearing.
- Sits between game/score logic and the board's display pins; generalises the single-digit BCD decoder to N digits, hex mode, decimal points and anti-ghost blanking.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+1).
- BLANK_CYCLES, 100, cycles at the start of each slot with all anodes off (anti-ghosting); 0 disables blanking.
- HEX_MODE, 0, 1 = decode nibbles 10..15 as A,b,C,d,E,F; 0 = BCD only.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe capturing value_in/dp_in.
- value_in  input  4*NUM_DIGITS  nibble k drives digit k (digit 0 = bits 3:0 = rightmost).
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- pending  output  1  a loaded value is waiting for the next frame boundary.
- frame_start  output  1  one-cycle pulse when the scan returns to digit 0.
- an  output  NUM_DIGITS  active-low anode enables, at most one low.
- segment  output  7  active-low segments, bit 6..0 = g,f,e,d,c,b,a.
- dp  output  1  active-low decimal point.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - Slot counter 0, digit index 0.
  - Active and pending registers 0, pending=0.
  - an = all ones, segment = 7'b1111111, dp = 1, frame_start = 0.
- Slot counter: counts 0..SCAN_DIV-1. On wrap, digit index increments; it wraps from NUM_DIGITS-1 to 0.
- Frame length is NUM_DIGITS*SCAN_DIV cycles.
- Boundary cycle: index = NUM_DIGITS-1 and counter = SCAN_DIV-1.
- Outputs are registered and reflect the internal (index, counter) state with 1 cycle latency.
- Anodes and blanking:
  - While counter < BLANK_CYCLES: an = all ones, segment = 7'b1111111, dp = 1.
  - Otherwise: an[index] = 0 and all other anode bits = 1; segment = decode(active nibble[index]); dp = ~active_dp[index].
- Decode table (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - HEX_MODE=1: A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - HEX_MODE=0: 10..15 decode to 0000000 (all segments lit, error indication).
- Load handshake:
  - When load=1, value_in/dp_in are captured into the pending register and pending=1 on the next cycle.
  - A load while pending=1 overwrites the pending value (last writer wins).
  - On the boundary cycle with pending=1, the pending value is copied to active and pending clears.
  - A load on the boundary cycle itself bypasses: value_in goes directly to active and pending stays 0.
- frame_start is registered high for exactly one cycle, aligned with the first output cycle of digit 0.
- Reset mid-frame: takes effect next edge; pending value is discarded; the scan restarts at digit 0 in its blanking window.
- NUM_DIGITS=1: index is constant 0; the boundary occurs every SCAN_DIV cycles.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - A digit k > 0 is blanked (its anode stays high, segment = 7'b1111111) if its nibble and every higher nibble are 0 and its dp bit is 0.
  - Digit 0 is never blanked.
  - Timing and frame_start are unchanged.
- When undefined: every digit is always driven.

Test Plan:
- Reset release, NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=1 -> an=1111 for 2 cycles, then an=1110 with segment=1000000, then an=1101 at cycle +9; frame_start pulses every 32 cycles.
- Load value_in=16'h1234, dp_in=4'b0100 mid-frame -> pending=1 until boundary; next frame shows digit0=0011001, digit1=0110000, digit2=0100100 with dp=0, digit3=1111001.
- HEX_MODE=1, load 16'hABCD -> segments 0100001, 1000110, 0000011, 0001000 on digits 0..3; HEX_MODE=0 with same load -> all 0000000.
- Two loads (16'h1111 then 16'h2222) before boundary, and a load asserted on the boundary cycle -> only 16'h2222 shown in the first case; bypass with pending=0 in the second.
- LEADING_ZERO_BLANK_EN, load 16'h0070 -> digits 3,2 anodes stay high, digit1=1111000, digit0=1000000; load 16'h0000 -> only digit0 lit.
- Reset asserted mid-slot at digit 2 with pending=1 -> next cycle pending=0, an=1111; the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-aligned double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seven_segment_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 100,
   parameter int HEX_MODE     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic                    pending,
   output logic                    frame_start,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              segment,
   output logic                    dp
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   // Slot timer runs down from CNT_RELOAD; a down-count of d is slot position SCAN_DIV-1-d,
   // so the blanking window (position < BLANK_CYCLES) is d >= SCAN_DIV-BLANK_CYCLES.
   localparam logic [CW-1:0] CNT_RELOAD = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_TC   = CW'((BLANK_CYCLES > 0) ? (SCAN_DIV - BLANK_CYCLES) : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]           cnt_q;
   logic [IW-1:0]           idx_q;
   logic [4*NUM_DIGITS-1:0] value_pend;
   logic [NUM_DIGITS-1:0]   dp_pend;
   logic [4*NUM_DIGITS-1:0] value_act;
   logic [NUM_DIGITS-1:0]   dp_act;

   logic                    slot_tc;
   logic                    boundary;
   logic                    in_blank;
   logic                    digit_blank;
   logic [3:0]              nib_sel;
   logic                    dp_sel;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [NUM_DIGITS-1:0]   an_d;
   logic [6:0]              seg_d;
   logic                    dp_d;

`ifdef LEADING_ZERO_BLANK_EN
   logic                    zero_run;
`endif

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = (HEX_MODE != 0) ? 7'b0001000 : 7'b0000000;
         4'hB: s = (HEX_MODE != 0) ? 7'b0000011 : 7'b0000000;
         4'hC: s = (HEX_MODE != 0) ? 7'b1000110 : 7'b0000000;
         4'hD: s = (HEX_MODE != 0) ? 7'b0100001 : 7'b0000000;
         4'hE: s = (HEX_MODE != 0) ? 7'b0000110 : 7'b0000000;
         default: s = (HEX_MODE != 0) ? 7'b0001110 : 7'b0000000;
      endcase
      return s;
   endfunction

   assign slot_tc  = (cnt_q == '0);
   assign boundary = slot_tc && (idx_q == IDX_LAST);
   assign in_blank = (BLANK_CYCLES > 0) && (cnt_q >= BLANK_TC);

   always_comb begin
      lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      // zero_run holds while every nibble from the top down to k is zero
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_run    = zero_run && (value_act[4*k +: 4] == 4'h0);
         lz_blank[k] = zero_run && !dp_act[k];
      end
`endif
      nib_sel     = 4'h0;
      dp_sel      = 1'b0;
      an_sel      = '1;
      digit_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            nib_sel     = value_act[4*k +: 4];
            dp_sel      = dp_act[k];
            an_sel[k]   = 1'b0;
            digit_blank = lz_blank[k];
         end
      end
      if (in_blank || digit_blank) begin
         an_d  = '1;
         seg_d = 7'b1111111;
         dp_d  = 1'b1;
      end else begin
         an_d  = an_sel;
         seg_d = decode(nib_sel);
         dp_d  = ~dp_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= CNT_RELOAD;
         idx_q       <= '0;
         value_pend  <= '0;
         dp_pend     <= '0;
         value_act   <= '0;
         dp_act      <= '0;
         pending     <= 1'b0;
         frame_start <= 1'b0;
         an          <= '1;
         segment     <= 7'b1111111;
         dp          <= 1'b1;
      end else begin
         if (slot_tc) begin
            cnt_q <= CNT_RELOAD;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end

         // A load on the boundary itself skips the pending stage entirely
         if (boundary) begin
            if (load) begin
               value_act <= value_in;
               dp_act    <= dp_in;
               pending   <= 1'b0;
            end else if (pending) begin
               value_act <= value_pend;
               dp_act    <= dp_pend;
               pending   <= 1'b0;
            end
         end else if (load) begin
            value_pend <= value_in;
            dp_pend    <= dp_in;
            pending    <= 1'b1;
         end

         frame_start <= (idx_q == '0) && (cnt_q == CNT_RELOAD);
         an          <= an_d;
         segment     <= seg_d;
         dp          <= dp_d;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner: 4 digits, 8-cycle slots, 1 blanking cycle, BCD and hex builds.
// Expectations follow LEADING_ZERO_BLANK_EN when that macro is defined for the build.
module tb_seven_segment_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;

   logic        pending, frame_start, dp;
   logic [3:0]  an;
   logic [6:0]  segment;
   logic        pending_h, frame_start_h, dp_h;
   logic [3:0]  an_h;
   logic [6:0]  segment_h;

   int checks = 0;
   int errors = 0;
   int n      = 0;

   always #5 clk = ~clk;

   seven_segment_scanner #(
      .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(1), .HEX_MODE(0)
   ) dut (
      .clk(clk), .reset(reset), .load(load), .value_in(value_in), .dp_in(dp_in),
      .pending(pending), .frame_start(frame_start), .an(an), .segment(segment), .dp(dp)
   );

   seven_segment_scanner #(
      .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(1), .HEX_MODE(1)
   ) dut_hex (
      .clk(clk), .reset(reset), .load(load), .value_in(value_in), .dp_in(dp_in),
      .pending(pending_h), .frame_start(frame_start_h), .an(an_h), .segment(segment_h), .dp(dp_h)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // n counts edges since reset release; outputs after edge n reflect frame position n mod 32
   task automatic tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic wait_n(input int target);
      while (n < target) tick();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      load     = 1'b1;
      value_in = v;
      dp_in    = d;
      tick();
      load     = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      load     = 1'b0;
      value_in = 16'h0;
      dp_in    = 4'h0;
      repeat (3) tick();
      check_val("rst_an", an, 4'b1111);
      check_val("rst_seg", segment, 7'b1111111);
      check_val("rst_dp", dp, 1'b1);
      check_val("rst_fs", frame_start, 1'b0);
      check_val("rst_pend", pending, 1'b0);

      reset = 1'b0;
      n = -1;
      tick();
      check_val("e0_an", an, 4'b1111);
      check_val("e0_fs", frame_start, 1'b1);
      tick();
      check_val("e1_an", an, 4'b1110);
      check_val("e1_seg", segment, 7'b1000000);
      check_val("e1_fs", frame_start, 1'b0);
      wait_n(8);
      check_val("e8_an", an, 4'b1111);
      wait_n(9);
`ifdef LEADING_ZERO_BLANK_EN
      check_val("e9_an", an, 4'b1111);
`else
      check_val("e9_an", an, 4'b1101);
`endif
      wait_n(31);
      check_val("e31_fs", frame_start, 1'b0);
      wait_n(32);
      check_val("e32_fs", frame_start, 1'b1);

      // mid-frame load waits for the boundary
      wait_n(40);
      do_load(16'h1234, 4'b0100);
      check_val("ld_pend", pending, 1'b1);
      wait_n(62);
      check_val("ld_pend_hold", pending, 1'b1);
      tick();
      check_val("ld_pend_clr", pending, 1'b0);
      wait_n(64);
      check_val("f2_fs", frame_start, 1'b1);
      wait_n(65);
      check_val("d0_an", an, 4'b1110);
      check_val("d0_seg", segment, 7'b0011001);
      check_val("d0_dp", dp, 1'b1);
      wait_n(73);
      check_val("d1_an", an, 4'b1101);
      check_val("d1_seg", segment, 7'b0110000);
      wait_n(81);
      check_val("d2_an", an, 4'b1011);
      check_val("d2_seg", segment, 7'b0100100);
      check_val("d2_dp", dp, 1'b0);
      wait_n(89);
      check_val("d3_an", an, 4'b0111);
      check_val("d3_seg", segment, 7'b1111001);
      check_val("d3_dp", dp, 1'b1);
      check_val("d3_seg_hex", segment_h, 7'b1111001);

      // hex digits vs BCD error pattern
      wait_n(100);
      do_load(16'hABCD, 4'b0000);
      wait_n(129);
      check_val("hx0", segment_h, 7'b0100001);
      check_val("bcd0", segment, 7'b0000000);
      wait_n(137);
      check_val("hx1", segment_h, 7'b1000110);
      check_val("bcd1", segment, 7'b0000000);
      wait_n(145);
      check_val("hx2", segment_h, 7'b0000011);
      wait_n(153);
      check_val("hx3", segment_h, 7'b0001000);
      check_val("bcd3", segment, 7'b0000000);
      check_val("hx3_an", an_h, 4'b0111);

      // last writer wins
      wait_n(160);
      do_load(16'h1111, 4'b0000);
      wait_n(170);
      do_load(16'h2222, 4'b0000);
      check_val("ll_pend", pending, 1'b1);
      wait_n(193);
      check_val("ll_d0", segment, 7'b0100100);
      wait_n(201);
      check_val("ll_d1", segment, 7'b0100100);

      // load exactly on the boundary bypasses pending
      wait_n(222);
      do_load(16'h5679, 4'b0000);
      check_val("byp_pend", pending, 1'b0);
      wait_n(224);
      check_val("byp_pend2", pending, 1'b0);
      wait_n(225);
      check_val("byp_d0", segment, 7'b0010000);
      wait_n(233);
      check_val("byp_d1", segment, 7'b1111000);

      // leading zeros
      wait_n(240);
      do_load(16'h0070, 4'b0000);
      wait_n(257);
      check_val("lz_d0_an", an, 4'b1110);
      check_val("lz_d0_seg", segment, 7'b1000000);
      wait_n(265);
      check_val("lz_d1_an", an, 4'b1101);
      check_val("lz_d1_seg", segment, 7'b1111000);
      wait_n(273);
`ifdef LEADING_ZERO_BLANK_EN
      check_val("lz_d2_an", an, 4'b1111);
      check_val("lz_d2_seg", segment, 7'b1111111);
`else
      check_val("lz_d2_an", an, 4'b1011);
      check_val("lz_d2_seg", segment, 7'b1000000);
`endif
      wait_n(281);
`ifdef LEADING_ZERO_BLANK_EN
      check_val("lz_d3_an", an, 4'b1111);
`else
      check_val("lz_d3_an", an, 4'b0111);
`endif
      wait_n(290);
      do_load(16'h0000, 4'b0000);
      wait_n(321);
      check_val("z_d0_an", an, 4'b1110);
      check_val("z_d0_seg", segment, 7'b1000000);
      wait_n(329);
`ifdef LEADING_ZERO_BLANK_EN
      check_val("z_d1_an", an, 4'b1111);
`else
      check_val("z_d1_an", an, 4'b1101);
`endif

      // reset mid-slot at digit 2 with a pending value
      wait_n(330);
      do_load(16'h9999, 4'b1111);
      check_val("mr_pend", pending, 1'b1);
      wait_n(340);
      reset = 1'b1;
      tick();
      check_val("mr_pend_clr", pending, 1'b0);
      check_val("mr_an", an, 4'b1111);
      check_val("mr_seg", segment, 7'b1111111);
      reset = 1'b0;
      n = -1;
      tick();
      check_val("mr_e0_fs", frame_start, 1'b1);
      check_val("mr_e0_an", an, 4'b1111);
      tick();
      check_val("mr_e1_an", an, 4'b1110);
      check_val("mr_e1_seg", segment, 7'b1000000);
      check_val("mr_e1_dp", dp, 1'b1);
      wait_n(32);
      check_val("mr_pend_post", pending, 1'b0);
      wait_n(33);
      check_val("mr_f2_seg", segment, 7'b1000000);
      check_val("mr_f2_dp", dp, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
